// File: rtl/usb_ctrl_in_pkt_buf.sv
// usb_ctrl_in_pkt_buf: single-packet IN buffer for control endpoint 0.
// Collects producer bytes into one packet of up to MAX_PKT_SIZE bytes and
// answers IN tokens with DATA/NAK/STALL. It tracks the DATA0/DATA1 toggle,
// retransmits when no ACK arrives, and reports ACKs back to the producer.
// Optional feature macro: USB_CTRL_IN_STATS_EN adds the pkt_cnt/retry_cnt
// statistics ports.
module usb_ctrl_in_pkt_buf #(
  parameter int MAX_PKT_SIZE = 32
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       in_ep_req,
  output logic       in_ep_grant,
  output logic       in_ep_data_free,
  input  logic       in_ep_data_put,
  input  logic [7:0] in_ep_data,
  input  logic       in_ep_data_done,
  input  logic       in_ep_stall,
  output logic       in_ep_acked,
  input  logic       tx_pkt_start,
  output logic       tx_pkt_ready,
  output logic       tx_stall,
  output logic       tx_data_pid,
  output logic       tx_data_avail,
  input  logic       tx_data_get,
  output logic [7:0] tx_data,
  input  logic       tx_handshake_ack,
  input  logic       setup_seen
`ifdef USB_CTRL_IN_STATS_EN
  ,
  output logic [15:0] pkt_cnt,
  output logic [15:0] retry_cnt
`endif
);

  localparam int AW = $clog2(MAX_PKT_SIZE);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] MAX_CNT = PW'(MAX_PKT_SIZE);

  typedef enum logic [2:0] {
    EMPTY    = 3'd0,
    FILLING  = 3'd1,
    READY    = 3'd2,
    SENDING  = 3'd3,
    WAIT_ACK = 3'd4
  } state_t;

  state_t state, state_d;

  logic [PW-1:0] wr_cnt, wr_cnt_d;
  logic [PW-1:0] rd_ptr, rd_ptr_d;
  logic          zlp_pend, zlp_pend_d;
  logic          pid_d, stall_d, acked_d;
  logic          wr_en, rd_load;
  logic          pkt_inc, retry_inc;
  logic          put_ok, full_pkt;

  logic [7:0] pkt_mem [MAX_PKT_SIZE];

  // Saturating increment for the 16-bit statistics counters.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Producer-side handshake; a stalled endpoint refuses writes until the next SETUP.
  assign in_ep_grant     = reset_n && in_ep_req && !tx_stall &&
                           (state == EMPTY || state == FILLING);
  assign in_ep_data_free = in_ep_grant && (wr_cnt < MAX_CNT);
  assign put_ok          = in_ep_data_put && in_ep_data_free;
  assign full_pkt        = (wr_cnt == MAX_CNT);

  // Transmitter-side status. wr_cnt doubles as the packet length once the packet is closed.
  assign tx_pkt_ready  = (state == READY || state == WAIT_ACK) && !tx_stall;
  assign tx_data_avail = (state == SENDING) && (rd_ptr < wr_cnt);

  // Next-state and control decode; SETUP beats everything, then a stall request.
  always_comb begin
    state_d    = state;
    wr_cnt_d   = wr_cnt;
    rd_ptr_d   = rd_ptr;
    zlp_pend_d = zlp_pend;
    pid_d      = tx_data_pid;
    stall_d    = tx_stall;
    acked_d    = 1'b0;
    wr_en      = 1'b0;
    rd_load    = 1'b0;
    pkt_inc    = 1'b0;
    retry_inc  = 1'b0;
    if (setup_seen) begin
      state_d    = EMPTY;
      wr_cnt_d   = '0;
      rd_ptr_d   = '0;
      zlp_pend_d = 1'b0;
      stall_d    = 1'b0;
      pid_d      = 1'b1;
    end else if (in_ep_stall) begin
      state_d    = EMPTY;
      wr_cnt_d   = '0;
      rd_ptr_d   = '0;
      zlp_pend_d = 1'b0;
      stall_d    = 1'b1;
    end else begin
      // A done request against a closed full packet queues a trailing ZLP.
      if (in_ep_data_done && full_pkt &&
          (state == READY || state == SENDING || state == WAIT_ACK))
        zlp_pend_d = 1'b1;
      case (state)
        EMPTY, FILLING: begin
          if (put_ok) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt + PW'(1);
            state_d  = (wr_cnt + PW'(1) == MAX_CNT) ? READY : FILLING;
          end
          if (in_ep_data_done && !tx_stall)
            state_d = READY;
        end
        READY: begin
          if (tx_pkt_start && !tx_stall) begin
            state_d  = SENDING;
            rd_ptr_d = '0;
            rd_load  = 1'b1;
          end
        end
        SENDING: begin
          if (rd_ptr == wr_cnt) begin
            state_d = WAIT_ACK;
          end else if (tx_data_get) begin
            rd_ptr_d = rd_ptr + PW'(1);
            rd_load  = 1'b1;
          end
        end
        WAIT_ACK: begin
          if (tx_handshake_ack) begin
            acked_d    = 1'b1;
            pid_d      = ~tx_data_pid;
            wr_cnt_d   = '0;
            rd_ptr_d   = '0;
            pkt_inc    = 1'b1;
            state_d    = (zlp_pend_d) ? READY : EMPTY;
            zlp_pend_d = 1'b0;
          end else if (tx_pkt_start && !tx_stall) begin
            state_d   = SENDING;
            rd_ptr_d  = '0;
            rd_load   = 1'b1;
            retry_inc = 1'b1;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // Control state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= EMPTY;
      wr_cnt      <= '0;
      rd_ptr      <= '0;
      zlp_pend    <= 1'b0;
      tx_data_pid <= 1'b0;
      tx_stall    <= 1'b0;
      in_ep_acked <= 1'b0;
    end else begin
      state       <= state_d;
      wr_cnt      <= wr_cnt_d;
      rd_ptr      <= rd_ptr_d;
      zlp_pend    <= zlp_pend_d;
      tx_data_pid <= pid_d;
      tx_stall    <= stall_d;
      in_ep_acked <= acked_d;
    end
  end

  // Packet storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk) begin
    if (wr_en)
      pkt_mem[wr_cnt[AW-1:0]] <= in_ep_data;
  end

  // Registered read port: presents the byte at the new read pointer.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      tx_data <= 8'h00;
    else if (rd_load)
      tx_data <= pkt_mem[rd_ptr_d[AW-1:0]];
  end

`ifdef USB_CTRL_IN_STATS_EN
  // ACKed-packet and retransmit counters, saturating.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt   <= 16'h0000;
      retry_cnt <= 16'h0000;
    end else begin
      if (pkt_inc)
        pkt_cnt <= sat_inc16(pkt_cnt);
      if (retry_inc)
        retry_cnt <= sat_inc16(retry_cnt);
    end
  end
`else
  // Without statistics the increment strobes have no consumer.
  logic stats_unused;
  assign stats_unused = pkt_inc ^ retry_inc;
`endif

endmodule
